// File: rtl/player_input_controller.sv
// player_input_controller: per-frame key debounce, last-pressed-wins walk direction
// and variable-height jump sequencing for a single player driven by two key sets.
module player_input_controller #(
   parameter int DEBOUNCE_FRAMES = 2,
   parameter int JUMP_MAX_FRAMES = 16,
   parameter int JUMP_CNT_W      = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_tick,
   input  logic                  w_key,
   input  logic                  a_key,
   input  logic                  d_key,
   input  logic                  arrow_up,
   input  logic                  arrow_left,
   input  logic                  arrow_right,
   input  logic                  landed,
   output logic                  move_left,
   output logic                  move_right,
   output logic                  facing_left,
   output logic                  jump_start,
   output logic                  jump_hold,
   output logic [JUMP_CNT_W-1:0] jump_cnt
);
   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
   typedef enum logic [1:0] {IDLE, LEFT, RIGHT} dir_t;
   typedef enum logic [1:0] {J_IDLE, J_RISE, J_AIR} jump_t;
   // bit 0 = left, bit 1 = right, bit 2 = up
   logic [2:0] raw, stable, stable_n, flip, rise;
   logic [CW-1:0] cnt [3];
   dir_t dir, dir_n;
   jump_t jst;
   assign raw = {w_key | arrow_up, d_key | arrow_right, a_key | arrow_left};
   always_comb begin
      for (int i = 0; i < 3; i++)
         flip[i] = (raw[i] != stable[i]) && (cnt[i] == CW'(DEBOUNCE_FRAMES - 1));
      stable_n = stable ^ flip;
      rise = flip & raw;
   end
   always_comb begin
      dir_n = dir;
      case (dir)
         IDLE:    dir_n = rise[1] ? RIGHT : rise[0] ? LEFT : IDLE;
         LEFT:    dir_n = rise[1] ? RIGHT : !stable_n[0] ? (stable_n[1] ? RIGHT : IDLE) : LEFT;
         RIGHT:   dir_n = rise[0] ? LEFT : !stable_n[1] ? (stable_n[0] ? LEFT : IDLE) : RIGHT;
         default: dir_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt         <= '{default: '0};
         stable      <= '0;
         dir         <= IDLE;
         jst         <= J_IDLE;
         move_left   <= 1'b0;
         move_right  <= 1'b0;
         facing_left <= 1'b0;
         jump_start  <= 1'b0;
         jump_hold   <= 1'b0;
         jump_cnt    <= '0;
      end else begin
         jump_start <= 1'b0;
         if (frame_tick) begin
            for (int i = 0; i < 3; i++)
               cnt[i] <= (raw[i] == stable[i] || flip[i]) ? '0 : cnt[i] + CW'(1);
            stable     <= stable_n;
            dir        <= dir_n;
            move_left  <= dir_n == LEFT;
            move_right <= dir_n == RIGHT;
            if (dir_n == LEFT) facing_left <= 1'b1;
            else if (dir_n == RIGHT) facing_left <= 1'b0;
            case (jst)
               J_IDLE:
                  if (rise[2] && landed) begin
                     jst        <= J_RISE;
                     jump_start <= 1'b1;
                     jump_hold  <= 1'b1;
                     jump_cnt   <= '0;
                  end
               J_RISE:
                  if (stable_n[2] && jump_cnt < JUMP_CNT_W'(JUMP_MAX_FRAMES - 1))
                     jump_cnt <= jump_cnt + JUMP_CNT_W'(1);
                  else begin
                     jst       <= J_AIR;
                     jump_hold <= 1'b0;
                  end
               J_AIR:
                  if (landed && !stable_n[2]) begin
                     jst      <= J_IDLE;
                     jump_cnt <= '0;
                  end
               default: jst <= J_IDLE;
            endcase
         end
      end
   end
endmodule
